// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: arbiter and read-modify-write sequencer for the shared,
// single-ported 2-bit saturating-counter branch predictor table.
// Optional feature macro: BP_INIT_SWEEP_EN (INIT writes 2'b11 to every entry).
`timescale 1ns/1ps

module bp_table_ctrl #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lookup_valid,
  input  logic [INDEX_W-1:0]        lookup_idx,
  output logic                      lookup_ready,
  output logic                      pred_valid,
  output logic                      pred_taken,
  input  logic                      resolve_valid,
  input  logic [INDEX_W-1:0]        resolve_idx,
  input  logic                      resolve_taken,
  output logic                      resolve_ready,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      tbl_en,
  output logic                      tbl_we,
  output logic [INDEX_W-1:0]        tbl_addr,
  output logic [1:0]                tbl_wdata,
  input  logic [1:0]                tbl_rdata
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LK_RESP,
    S_UPD_RD,
    S_UPD_WR
  } state_t;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               taken;
  } res_t;

  state_t             state;
  state_t             state_d;
  res_t               q_mem [QDEPTH];
  res_t               head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   q_cnt;
  logic               q_full;
  logic               q_empty;
  logic               push;
  logic               pop;
  logic [1:0]         upd_ctr;
  logic [1:0]         ctr_nxt;
`ifdef BP_INIT_SWEEP_EN
  logic [INDEX_W-1:0] sweep_cnt;
`endif

  assign head          = q_mem[rd_ptr];
  assign q_full        = (q_cnt == CNT_W'(QDEPTH));
  assign q_empty       = (q_cnt == '0);
  assign q_count       = q_cnt;
  // Pushes are accepted in every non-INIT state; the readiness uses the
  // registered count, so a same-cycle pop never opens an extra slot.
  assign resolve_ready = !reset && (state != S_INIT) && !q_full;
  assign push          = resolve_valid && resolve_ready;
  assign pop           = !reset && (state == S_UPD_WR);

  // Saturating counter update for the queue head, applied to the value just read
  always_comb begin
    ctr_nxt = tbl_rdata;
    if (head.taken) begin
      if (tbl_rdata != 2'b11) ctr_nxt = tbl_rdata + 2'd1;
    end else begin
      if (tbl_rdata != 2'b00) ctr_nxt = tbl_rdata - 2'd1;
    end
  end

  // Next-state and table/handshake outputs; everything is quiet while reset is high
  always_comb begin
    state_d      = state;
    lookup_ready = 1'b0;
    pred_valid   = 1'b0;
    pred_taken   = 1'b0;
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = 2'b00;
    if (!reset) begin
      unique case (state)
        S_INIT: begin
`ifdef BP_INIT_SWEEP_EN
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = sweep_cnt;
          tbl_wdata = 2'b11;
          if (&sweep_cnt) state_d = S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
        S_IDLE: begin
          // A full queue blocks lookups so pending updates cannot starve
          lookup_ready = !q_full;
          if (lookup_valid && !q_full) begin
            tbl_en   = 1'b1;
            tbl_addr = lookup_idx;
            state_d  = S_LK_RESP;
          end else if (!q_empty) begin
            tbl_en   = 1'b1;
            tbl_addr = head.idx;
            state_d  = S_UPD_RD;
          end
        end
        S_LK_RESP: begin
          pred_valid = 1'b1;
          pred_taken = tbl_rdata[1];
          state_d    = S_IDLE;
        end
        S_UPD_RD: begin
          state_d = S_UPD_WR;
        end
        S_UPD_WR: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = head.idx;
          tbl_wdata = upd_ctr;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  // State, queue pointers/count and the latched updated counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_INIT;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      upd_ctr <= 2'b00;
`ifdef BP_INIT_SWEEP_EN
      sweep_cnt <= '0;
`endif
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
      if (state == S_UPD_RD) upd_ctr <= ctr_nxt;
`ifdef BP_INIT_SWEEP_EN
      if (state == S_INIT) sweep_cnt <= sweep_cnt + INDEX_W'(1);
`endif
    end
  end

  // Resolution queue storage; contents need no reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= '{idx: resolve_idx, taken: resolve_taken};
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Testbench for bp_table_ctrl: behavioural table RAM, reference counter model
// and a scoreboard monitor. Honours BP_INIT_SWEEP_EN when defined.
`timescale 1ns/1ps

module tb_bp_table_ctrl;

  localparam int IW   = 4;
  localparam int QD   = 4;
  localparam int NENT = 1 << IW;
`ifdef BP_INIT_SWEEP_EN
  localparam int INIT_CYC = NENT;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lookup_valid = 1'b0;
  logic [IW-1:0] lookup_idx = '0;
  logic          lookup_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic          resolve_valid = 1'b0;
  logic [IW-1:0] resolve_idx = '0;
  logic          resolve_taken = 1'b0;
  logic          resolve_ready;
  logic [$clog2(QD):0] q_count;
  logic          tbl_en;
  logic          tbl_we;
  logic [IW-1:0] tbl_addr;
  logic [1:0]    tbl_wdata;
  logic [1:0]    tbl_rdata = 2'b00;

  bp_table_ctrl #(.INDEX_W(IW), .QDEPTH(QD)) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_valid  (lookup_valid),
    .lookup_idx    (lookup_idx),
    .lookup_ready  (lookup_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_idx   (resolve_idx),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .q_count       (q_count),
    .tbl_en        (tbl_en),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .tbl_rdata     (tbl_rdata)
  );

  always #5 clk = ~clk;

  // Counter table RAM: synchronous read, one-cycle latency, preloaded strongly taken
  logic [1:0] mem [NENT] = '{default: 2'b11};
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [1:0]    val;
  } wr_exp_t;

  typedef struct {
    bit taken;
    int due;
  } pr_exp_t;

  // Reference model: ref_ctr runs ahead in resolution order, committed tracks the RAM
  wr_exp_t wr_q [$];
  pr_exp_t pr_q [$];
  int      ref_ctr   [NENT] = '{default: 3};
  int      committed [NENT] = '{default: 3};
  int      mcount = 0;
  int      cyc = 0;
  int      init_left = 0;
  bit      prev_reset = 1'b0;
  int      n_cmp = 0;
  int      n_fail = 0;
  bit      final_done = 1'b0;
  wr_exp_t we_e;
  pr_exp_t pe_e;
  int      w_have;
  logic [IW+3:0] sw_want;

  // Owned by the stimulus process
  int      tmo = 0;
  bit      chk_reset = 1'b0;
  bit      final_chk = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endfunction

  function automatic int bump(input int c, input bit taken);
    int v;
    v = taken ? c + 1 : c - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  // Monitor/scoreboard: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (final_chk && !final_done) begin
      chk("drain_writes", wr_q.size(), 0);
      chk("drain_preds", pr_q.size(), 0);
      chk("timeouts", tmo, 0);
      final_done = 1'b1;
    end
    if (reset) begin
      if (chk_reset) begin
        chk("reset_outs", int'({lookup_ready, resolve_ready, pred_valid, pred_taken,
                                tbl_en, tbl_we, tbl_addr, tbl_wdata}), 0);
        if (prev_reset) chk("reset_qcount", int'(q_count), 0);
      end
      wr_q.delete();
      pr_q.delete();
      mcount    = 0;
      init_left = INIT_CYC;
      for (int i = 0; i < NENT; i++) begin
`ifdef BP_INIT_SWEEP_EN
        committed[i] = 3;
`endif
        ref_ctr[i] = committed[i];
      end
    end else if (init_left > 0) begin
      chk("init_readies", int'({lookup_ready, resolve_ready, pred_valid}), 0);
`ifdef BP_INIT_SWEEP_EN
      sw_want = {1'b1, 1'b1, IW'(INIT_CYC - init_left), 2'b11};
      chk("init_sweep", int'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), int'(sw_want));
`else
      chk("init_quiet", int'(tbl_en), 0);
`endif
      init_left--;
    end else begin
      chk("q_count", int'(q_count), mcount);
      chk("resolve_ready", int'(resolve_ready), int'(mcount < QD));
      if (mcount == QD) chk("lookup_ready_full", int'(lookup_ready), 0);

      if (pr_q.size() > 0 && pr_q[0].due == cyc) begin
        chk("pred_valid", int'(pred_valid), 1);
        pe_e = pr_q.pop_front();
        if (pred_valid) chk("pred_taken", int'(pred_taken), int'(pe_e.taken));
      end else begin
        chk("pred_spurious", int'(pred_valid), 0);
      end

      if (tbl_en && tbl_we) begin
        w_have = wr_q.size();
        chk("write_pending", int'(w_have > 0), 1);
        if (w_have > 0) begin
          we_e = wr_q.pop_front();
          chk("write_addr", int'(tbl_addr), int'(we_e.idx));
          chk("write_data", int'(tbl_wdata), int'(we_e.val));
          committed[we_e.idx] = int'(we_e.val);
          mcount--;
        end
      end

      if (lookup_valid && lookup_ready) begin
        chk("lookup_read", int'({tbl_en, tbl_we, tbl_addr}), int'({1'b1, 1'b0, lookup_idx}));
        pe_e.taken = (committed[lookup_idx] >= 2);
        pe_e.due   = cyc + 1;
        pr_q.push_back(pe_e);
      end

      if (resolve_valid && resolve_ready) begin
        ref_ctr[resolve_idx] = bump(ref_ctr[resolve_idx], resolve_taken);
        we_e.idx = resolve_idx;
        we_e.val = 2'(ref_ctr[resolve_idx]);
        wr_q.push_back(we_e);
        mcount++;
      end
    end
    prev_reset = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic [IW-1:0] idx, input bit taken);
    bit acc;
    acc = 1'b0;
    resolve_valid = 1'b1;
    resolve_idx   = idx;
    resolve_taken = taken;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = resolve_ready;
      tick();
    end
    if (!acc) tmo++;
  endtask

  task automatic do_lookup(input logic [IW-1:0] idx);
    bit acc;
    acc = 1'b0;
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = lookup_ready;
      tick();
    end
    lookup_valid = 1'b0;
    if (!acc) tmo++;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (wr_q.size() == 0 && pr_q.size() == 0) done = 1'b1;
      else tick();
    end
    if (!done) tmo++;
    repeat (2) tick();
  endtask

  task automatic run_random(input int n, input int p_lk, input int p_rs, input int idx_mask);
    int lk_wait;
    int rs_wait;
    bit lk_acc;
    bit rs_acc;
    lk_wait = 0;
    rs_wait = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lk_acc = lookup_valid && lookup_ready;
      rs_acc = resolve_valid && resolve_ready;
      tick();
      if (lookup_valid && !lk_acc && lk_wait < 64) begin
        lk_wait++;
      end else begin
        if (lookup_valid && !lk_acc) tmo++;
        lk_wait      = 0;
        lookup_valid = ($urandom_range(99) < p_lk);
        lookup_idx   = IW'($urandom() & idx_mask);
      end
      if (resolve_valid && !rs_acc && rs_wait < 64) begin
        rs_wait++;
      end else begin
        if (resolve_valid && !rs_acc) tmo++;
        rs_wait       = 0;
        resolve_valid = ($urandom_range(99) < p_rs);
        resolve_idx   = IW'($urandom() & idx_mask);
        resolve_taken = $urandom_range(1) == 1;
      end
    end
    lookup_valid  = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
    repeat (INIT_CYC + 1) tick();
  endtask

  initial begin
    bit found;
    @(posedge clk);
    #1;
    chk_reset = 1'b1;
    apply_reset(3);

    // Fresh table predicts taken
    do_lookup(IW'(5));
    wait_drain();

    // Two not-taken at idx 3: 11 -> 10 -> 01, then predict not-taken
    push_res(IW'(3), 1'b0);
    push_res(IW'(3), 1'b0);
    resolve_valid = 1'b0;
    wait_drain();
    do_lookup(IW'(3));
    wait_drain();

    // Saturation at both ends
    for (int i = 0; i < 3; i++) push_res(IW'(7), 1'b1);
    for (int i = 0; i < 6; i++) push_res(IW'(9), 1'b0);
    resolve_valid = 1'b0;
    wait_drain();
    do_lookup(IW'(9));
    do_lookup(IW'(7));
    wait_drain();

    // Queue fills while fetch holds a lookup; updates take over at full
    lookup_idx   = IW'(2);
    lookup_valid = 1'b1;
    for (int i = 0; i < 6; i++) push_res(IW'(10 + i), (i % 2) == 0);
    resolve_valid = 1'b0;
    repeat (4) tick();
    lookup_valid = 1'b0;
    wait_drain();

    // Random traffic: dense collisions, then the full index range
    run_random(1500, 40, 55, 3);
    wait_drain();
    run_random(1500, 50, 35, NENT - 1);
    wait_drain();

    // Reset landing in UPD_RD with three entries queued
    lookup_idx   = IW'(1);
    lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) push_res(IW'(4 + i), 1'b0);
    resolve_valid = 1'b0;
    lookup_valid  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (tbl_en && !tbl_we && !(lookup_valid && lookup_ready)) found = 1'b1;
    end
    if (!found) tmo++;
    tick();
    apply_reset(2);

    // Traffic after the mid-operation reset
    run_random(400, 45, 45, NENT - 1);
    wait_drain();

    final_chk = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
# bp_table_ctrl

Controller for the shared, single-ported 2-bit saturating-counter table behind the branch predictor. It arbitrates table access between fetch-side lookups and execute-side resolutions. Resolutions are buffered in a small queue and retired as read-modify-write updates. Fetch gets a taken/not-taken prediction one cycle after its lookup is accepted. The block sits between the fetch/decode control FSM, the execute-stage branch unit, and the counter table RAM, which has synchronous read and 1-cycle latency.

## Interface
- INDEX_W, 4, table index width; the table holds 2^INDEX_W counters
- QDEPTH, 4, resolution queue depth (power of two, ≥2)
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- lookup_valid  input  1  fetch requests a prediction
- lookup_idx  input  INDEX_W  table index for the lookup
- lookup_ready  output  1  lookup accepted when valid&&ready
- pred_valid  output  1  one-cycle pulse: prediction available
- pred_taken  output  1  predicted direction (counter bit 1)
- resolve_valid  input  1  execute reports a resolved branch
- resolve_idx  input  INDEX_W  index of the resolved branch
- resolve_taken  input  1  actual outcome
- resolve_ready  output  1  queue can accept a resolution
- q_count  output  $clog2(QDEPTH)+1  queued resolutions
- tbl_en  output  1  table access strobe
- tbl_we  output  1  write enable (valid with tbl_en)
- tbl_addr  output  INDEX_W  table address
- tbl_wdata  output  2  counter write data
- tbl_rdata  input  2  counter read data, valid the cycle after a read

## Operation
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. pred_taken = rdata[1].
- Update rule: taken → min(c+1, 3); not-taken → max(c−1, 0). Saturate, never wrap.
- FSM states: INIT, IDLE, LK_RESP, UPD_RD, UPD_WR.
- INIT: see Configuration. Ends in IDLE.
- IDLE, queue not full, lookup_valid: lookup_ready=1. Drives tbl_en=1, we=0, addr=lookup_idx in the same cycle, then goes to LK_RESP.
- IDLE, queue full (q_count==QDEPTH): lookup_ready=0. Updates take priority (anti-starvation).
- IDLE, no accepted lookup, queue non-empty: read head idx (tbl_en=1, we=0), then go to UPD_RD.
- LK_RESP: pred_valid=1, pred_taken=tbl_rdata[1]; lookup_ready=0; next state IDLE.
- UPD_RD: latch tbl_rdata, compute new counter, go to UPD_WR.
- UPD_WR: tbl_en=1, we=1, addr=head idx, wdata=new counter; pop queue; go to IDLE.
- Queue push: resolve_valid&&resolve_ready, in any state except INIT. Push is independent of the FSM.
- resolve_ready = !INIT && q_count<QDEPTH. A pop in the same cycle does not raise ready.
- Simultaneous push and pop: q_count unchanged. Entries retire strictly in FIFO order.
- Same-index updates queued back to back apply sequentially; each RMW sees the previous write.
- tbl_en=0 in all cycles not listed above.

## Timing
- Reset values: lookup_ready=0, resolve_ready=0, pred_valid=0, pred_taken=0, q_count=0, tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
- Lookup latency: accept at cycle T, pred_valid at T+1. Lookup throughput is at most one per 2 cycles.
- Update: head read at T, write at T+2, pop at T+2. The earliest next table access is T+3.
- Reset asserted mid-operation, in any state: the queue is flushed, an in-flight lookup produces no pred_valid, a partial RMW writes nothing, and the FSM restarts at INIT.
- Unaccepted lookups are not stored. Fetch holds lookup_valid/lookup_idx until accepted.

## Configuration
- BP_INIT_SWEEP_EN defined: INIT writes 2'b11 to every entry, addr 0..2^INDEX_W−1, one per cycle (tbl_en=1, we=1). Then IDLE. Both readies stay 0 for 2^INDEX_W cycles after reset deasserts.
- BP_INIT_SWEEP_EN undefined: INIT lasts exactly one cycle with no table write. The table contents are owned by the RAM's own initialisation.

## Test plan
- Reset release with sweep enabled, INDEX_W=4 → 16 writes of 2'b11 to addr 0..15; resolve_ready rises at cycle 17; a lookup at idx 5 → pred_valid next cycle, pred_taken=1.
- Two not-taken resolutions at idx 3, then lookup idx 3 → counter 11→10→01; pred_taken=0; tbl_wdata sequence 10, 01.
- Saturation: three taken resolutions at an idx holding 11 → every write is 11. Three not-taken resolutions at an idx holding 00 → every write is 00.
- Hold lookup_valid continuously while pushing 4 resolutions (QDEPTH=4) → resolve_ready=0 at q_count=4; lookup_ready=0 until the first UPD_WR pop; then lookups resume.
- Push and pop in the same cycle at q_count=2 → q_count stays 2; FIFO order is preserved on the next writes.
- Assert reset during UPD_RD with q_count=3 → no write issued, no pred_valid, q_count=0; the INIT sweep restarts.
